// File: rtl/jtopl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jtopl_pkg
// Brief   : Shared constants and helpers for the OPL phase generator: slot
//           count, slot index width and the x2 frequency multiplier table.
// Revision: 1.0 - initial release
// ============================================================================
package jtopl_pkg;

    localparam int c_FNUM_W  = 10;
    localparam int c_PHINC_W = 17;
    localparam int c_PROD_W  = 22;

    // Total number of time slots serviced by one generator
    function automatic int num_slots(input int ch, input int ops);
        return ch * ops;
    endfunction

    // Index width for a slot counter; never narrower than one bit
    function automatic int slot_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Multiplier code to twice the frequency factor (0.5x is stored as 1)
    function automatic logic [4:0] mul_x2(input logic [3:0] mul);
        logic [4:0] f;
        case (mul)
            4'd0:    f = 5'd1;
            4'd1:    f = 5'd2;
            4'd2:    f = 5'd4;
            4'd3:    f = 5'd6;
            4'd4:    f = 5'd8;
            4'd5:    f = 5'd10;
            4'd6:    f = 5'd12;
            4'd7:    f = 5'd14;
            4'd8:    f = 5'd16;
            4'd9:    f = 5'd18;
            4'd10:   f = 5'd20;
            4'd11:   f = 5'd20;
            4'd12:   f = 5'd24;
            4'd13:   f = 5'd24;
            4'd14:   f = 5'd30;
            default: f = 5'd30;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtopl_sh_rst.sv
`default_nettype none
// ============================================================================
// Module  : jtopl_sh_rst
// Brief   : Clock-enabled shift register with synchronous active-high clear.
//           Used as the per-slot storage loop of the phase generator.
// Revision: 1.0 - initial release
// ============================================================================
module jtopl_sh_rst #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] drop
);

    logic [WIDTH-1:0] r_bits [STAGES];

    // Shift one position per enable; clear overrides the enable
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) r_bits[i] <= '0;
        end else if (cen) begin
            r_bits[0] <= din;
            for (int i = 1; i < STAGES; i++) r_bits[i] <= r_bits[i-1];
        end
    end

    assign drop = r_bits[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/jtopl_pg_mux.sv
`default_nettype none
// ============================================================================
// Module  : jtopl_pg_mux
// Brief   : Parametrised time-multiplexed phase generator. Stage I applies
//           vibrato and block shift, stage II the multiplier, stage III the
//           accumulation against a per-slot storage loop; the post-update
//           phase is registered out three enables after stage I.
// Revision: 1.0 - initial release
// ============================================================================
module jtopl_pg_mux
    import jtopl_pkg::*;
#(
    parameter int CH   = 9,
    parameter int OPS  = 2,
    parameter int PHW  = 20,
    parameter int OUTW = 10,
    localparam int SLOTS = num_slots(CH, OPS),
    localparam int SW    = slot_w(SLOTS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cenop,
    input  logic [9:0]      fnum_I,
    input  logic [2:0]      block_I,
    input  logic [2:0]      lfo_pos_I,
    input  logic            viben_I,
    input  logic            vib_dep,
    input  logic            nts,
    input  logic [3:0]      mul_II,
    input  logic            keyon_II,
    input  logic            pg_rst_II,
    input  logic            test_frz,
    output logic [3:0]      keycode_II,
    output logic [SW-1:0]   slot_IV,
    output logic            zero_IV,
    output logic [OUTW-1:0] phase_IV
);

    logic [SW-1:0]           r_cnt;
    logic [SW-1:0]           r_slot_II;
    logic [c_PHINC_W-1:0]    r_phinc_II;
    logic [SW-1:0]           r_slot_III;
    logic [PHW-1:0]          r_inc_III;
    logic                    r_keyon_III;
    logic                    r_pgrst_III;
    logic                    r_frz_III;
    logic [SW-1:0]           r_slot_acc;
    logic [OUTW-1:0]         r_phase_acc;

    logic [2:0]              w_vib_r;
    logic [10:0]             w_fnum_v;
    logic [c_PHINC_W-1:0]    w_phinc_I;
    logic [c_PROD_W-1:0]     w_prod;
    logic [PHW-1:0]          w_inc_II;
    logic                    w_hist_old;
    logic [PHW-1:0]          w_acc_old;
    logic [PHW-1:0]          w_acc_new;
    logic [PHW:0]            w_loop_in;
    logic [PHW:0]            w_loop_out;
    logic                    w_loop_rst;

    // Stage I: vibrato offset on fnum, then octave shift into the increment
    always_comb begin
        w_vib_r = fnum_I[9:7];
        if (lfo_pos_I[0]) w_vib_r = w_vib_r >> 1;
        if (!vib_dep)     w_vib_r = w_vib_r >> 1;
        if (lfo_pos_I[1:0] == 2'd0 || !viben_I) w_vib_r = 3'd0;
        // the offset is at most fnum[9:7], so subtraction cannot wrap
        w_fnum_v  = lfo_pos_I[2] ? ({1'b0, fnum_I} - 11'(w_vib_r))
                                 : ({1'b0, fnum_I} + 11'(w_vib_r));
        w_phinc_I = c_PHINC_W'(({7'd0, w_fnum_v} << block_I) >> 1);
    end

    // Stage II: apply the x2 multiplier table and halve
    always_comb begin
        w_prod   = c_PROD_W'(r_phinc_II) * c_PROD_W'(mul_x2(mul_II));
        w_inc_II = PHW'(w_prod >> 1);
    end

    // Stage III: accumulate against the slot's stored phase; resets beat freeze
    always_comb begin
        w_hist_old = w_loop_out[PHW];
        w_acc_old  = w_loop_out[PHW-1:0];
        w_acc_new  = w_acc_old + r_inc_III;
        if (r_frz_III) w_acc_new = w_acc_old;
        if (r_pgrst_III || (r_keyon_III && !w_hist_old)) w_acc_new = '0;
        w_loop_in  = {r_keyon_III, w_acc_new};
    end

    assign w_loop_rst = ~rst;

    // One entry per slot; the value read out belongs to the slot now in stage III
    jtopl_sh_rst #(
        .WIDTH  (PHW + 1),
        .STAGES (SLOTS)
    ) u_loop (
        .clk  (clk),
        .rst  (w_loop_rst),
        .cen  (cenop),
        .din  (w_loop_in),
        .drop (w_loop_out)
    );

    // Slot counter and pipeline registers, all advanced by the operator enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_slot_II   <= '0;
            r_phinc_II  <= '0;
            keycode_II  <= '0;
            r_slot_III  <= '0;
            r_inc_III   <= '0;
            r_keyon_III <= 1'b0;
            r_pgrst_III <= 1'b0;
            r_frz_III   <= 1'b0;
            r_slot_acc  <= '0;
            r_phase_acc <= '0;
            slot_IV     <= '0;
            phase_IV    <= '0;
        end else if (cenop) begin
            r_cnt       <= (r_cnt == SW'(SLOTS - 1)) ? '0 : r_cnt + SW'(1);
            r_slot_II   <= r_cnt;
            r_phinc_II  <= w_phinc_I;
            keycode_II  <= {block_I, nts ? fnum_I[8] : fnum_I[9]};
            r_slot_III  <= r_slot_II;
            r_inc_III   <= w_inc_II;
            r_keyon_III <= keyon_II;
            r_pgrst_III <= pg_rst_II;
            r_frz_III   <= test_frz;
            r_slot_acc  <= r_slot_III;
            r_phase_acc <= w_acc_new[PHW-1 -: OUTW];
            slot_IV     <= r_slot_acc;
            phase_IV    <= r_phase_acc;
        end
    end

    assign zero_IV = (slot_IV == '0);

endmodule
`default_nettype wire

// File: tb/tb_jtopl_pg_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtopl_pg_mux
// Brief   : Scoreboard bench for jtopl_pg_mux with an arithmetic phase model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jtopl_pg_mux;

    localparam int c_SLOTS = 18;
    localparam longint c_MASK = 64'hFFFFF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cenop = 1'b0;
    logic [9:0] fnum_I = '0;
    logic [2:0] block_I = '0;
    logic [2:0] lfo_pos_I = '0;
    logic       viben_I = 1'b0;
    logic       vib_dep = 1'b0;
    logic       nts = 1'b0;
    logic [3:0] mul_II = '0;
    logic       keyon_II = 1'b0;
    logic       pg_rst_II = 1'b0;
    logic       test_frz = 1'b0;

    logic [3:0] keycode_II;
    logic [4:0] slot_IV;
    logic       zero_IV;
    logic [9:0] phase_IV;

    logic [3:0] keycode2;
    logic [6:0] slot2;
    logic       zero2;
    logic [9:0] phase2;

    jtopl_pg_mux dut (
        .clk(clk), .rst(rst), .cenop(cenop), .fnum_I(fnum_I), .block_I(block_I),
        .lfo_pos_I(lfo_pos_I), .viben_I(viben_I), .vib_dep(vib_dep), .nts(nts),
        .mul_II(mul_II), .keyon_II(keyon_II), .pg_rst_II(pg_rst_II), .test_frz(test_frz),
        .keycode_II(keycode_II), .slot_IV(slot_IV), .zero_IV(zero_IV), .phase_IV(phase_IV)
    );

    jtopl_pg_mux #(.CH(18), .OPS(4)) dut2 (
        .clk(clk), .rst(rst), .cenop(cenop), .fnum_I(fnum_I), .block_I(block_I),
        .lfo_pos_I(lfo_pos_I), .viben_I(viben_I), .vib_dep(vib_dep), .nts(nts),
        .mul_II(mul_II), .keyon_II(keyon_II), .pg_rst_II(pg_rst_II), .test_frz(test_frz),
        .keycode_II(keycode2), .slot_IV(slot2), .zero_IV(zero2), .phase_IV(phase2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] fnum;
        logic [2:0] block;
        logic [2:0] lfo;
        logic       viben;
        logic [3:0] mul;
        logic       keyon;
        logic       pgrst;
        logic       frz;
    } rec_t;

    typedef struct {
        int due;
        int slot;
        int val;
    } exp_t;

    rec_t   stim [c_SLOTS];
    exp_t   q_ph [$];
    exp_t   q_kc [$];
    int     tabx2 [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
    longint acc_m [c_SLOTS];
    bit     hist_m [c_SLOTS];

    int     n_checks = 0;
    int     n_fail = 0;
    int     edge_cnt = 0;
    int     cnt_m = 0;
    bit     prev_v = 0;
    rec_t   prev;
    int     prev_slot = 0;
    longint prev_phinc = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: vibrato-adjusted fnum and block-shifted increment
    function automatic longint model_phinc(input rec_t r, input bit dep);
        int f, v;
        f = int'(r.fnum);
        v = f / 128;
        if (r.lfo % 2 == 1) v = v / 2;
        if (!dep) v = v / 2;
        if (r.lfo % 4 == 0 || !r.viben) v = 0;
        f = (r.lfo >= 4) ? f - v : f + v;
        return ((longint'(f) * (64'd1 << r.block)) / 2) % 131072;
    endfunction

    // One operator-enable edge: stage I for the current slot, stage II for the previous one
    task automatic step();
        rec_t cur;
        longint inc;
        int kc;
        cur = stim[cnt_m];
        cenop     = 1'b1;
        fnum_I    = cur.fnum;
        block_I   = cur.block;
        lfo_pos_I = cur.lfo;
        viben_I   = cur.viben;
        mul_II    = prev_v ? prev.mul : 4'd0;
        keyon_II  = prev_v ? prev.keyon : 1'b0;
        pg_rst_II = prev_v ? prev.pgrst : 1'b0;
        test_frz  = prev_v ? prev.frz : 1'b0;
        @(posedge clk);
        #1;
        edge_cnt++;
        kc = int'(cur.block) * 2 + int'(nts ? cur.fnum[8] : cur.fnum[9]);
        q_kc.push_back('{edge_cnt, cnt_m, kc});
        if (prev_v) begin
            inc = (prev_phinc * tabx2[prev.mul] / 2) & c_MASK;
            if (prev.pgrst || (prev.keyon && !hist_m[prev_slot]))
                acc_m[prev_slot] = 0;
            else if (!prev.frz)
                acc_m[prev_slot] = (acc_m[prev_slot] + inc) & c_MASK;
            hist_m[prev_slot] = prev.keyon;
            q_ph.push_back('{edge_cnt + 2, prev_slot, int'(acc_m[prev_slot] / 1024)});
        end
        prev       = cur;
        prev_phinc = model_phinc(cur, vib_dep);
        prev_slot  = cnt_m;
        prev_v     = 1;
        cnt_m      = (cnt_m + 1) % c_SLOTS;
    endtask

    task automatic run_round();
        for (int s = 0; s < c_SLOTS; s++) step();
    endtask

    task automatic do_reset();
        q_ph.delete();
        q_kc.delete();
        rst = 1'b0;
        cenop = 1'b1;
        mul_II = '0; keyon_II = 1'b0; pg_rst_II = 1'b0; test_frz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_phase", int'(phase_IV), 0);
        check("rst_slot", int'(slot_IV), 0);
        check("rst_zero", int'(zero_IV), 1);
        check("rst_keycode", int'(keycode_II), 0);
        check("rst_slot2", int'(slot2), 0);
        edge_cnt = 0;
        cnt_m = 0;
        prev_v = 0;
        for (int s = 0; s < c_SLOTS; s++) begin
            acc_m[s] = 0;
            hist_m[s] = 0;
        end
        rst = 1'b1;
    endtask

    // Enable held low: scramble inputs and require every output to hold
    task automatic gap(input int n);
        logic [9:0] p;
        logic [4:0] s;
        logic [3:0] k;
        p = phase_IV; s = slot_IV; k = keycode_II;
        cenop = 1'b0;
        fnum_I = 10'($urandom);
        block_I = 3'($urandom);
        keyon_II = 1'b1;
        pg_rst_II = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("gap_phase", int'(phase_IV), int'(p));
            check("gap_slot", int'(slot_IV), int'(s));
            check("gap_keycode", int'(keycode_II), int'(k));
        end
    endtask

    task automatic clear_stim();
        for (int s = 0; s < c_SLOTS; s++) stim[s] = '0;
    endtask

    task automatic random_stim();
        for (int s = 0; s < c_SLOTS; s++) begin
            stim[s].fnum  = 10'($urandom);
            stim[s].block = 3'($urandom);
            stim[s].lfo   = 3'($urandom);
            stim[s].viben = 1'($urandom);
            stim[s].mul   = 4'($urandom);
            stim[s].keyon = ($urandom_range(0, 3) != 0);
            stim[s].pgrst = ($urandom_range(0, 15) == 0);
            stim[s].frz   = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Scoreboard monitor: compares whichever expectations fall due on this edge
    always @(negedge clk) begin
        exp_t e;
        while (q_ph.size() > 0 && q_ph[0].due <= edge_cnt) begin
            e = q_ph.pop_front();
            check("phase_due", edge_cnt, e.due);
            check("slot_IV", int'(slot_IV), e.slot);
            check("zero_IV", int'(zero_IV), (e.slot == 0) ? 1 : 0);
            check("phase_IV", int'(phase_IV), e.val);
        end
        while (q_kc.size() > 0 && q_kc[0].due <= edge_cnt) begin
            e = q_kc.pop_front();
            check("kc_due", edge_cnt, e.due);
            check("keycode_II", int'(keycode_II), e.val);
        end
    end

    initial begin
        clear_stim();
        @(negedge clk);
        do_reset();

        // Accumulation on slot 0 with three multipliers
        stim[0].fnum = 10'h200; stim[0].block = 3'd4; stim[0].mul = 4'd1;
        repeat (20) run_round();
        stim[0].mul = 4'd0;
        repeat (10) run_round();
        stim[0].mul = 4'd11;
        repeat (10) run_round();

        // Full wrap of the 20-bit accumulator after 256 rounds
        do_reset();
        stim[0].mul = 4'd1;
        repeat (256) run_round();

        // Key-on edge, held key, forced reset, freeze with a key edge
        do_reset();
        stim[2].fnum = 10'h155; stim[2].block = 3'd3; stim[2].mul = 4'd5;
        repeat (9) run_round();
        stim[0].keyon = 1'b1; stim[2].keyon = 1'b1;
        run_round();
        repeat (4) run_round();
        stim[0].pgrst = 1'b1;
        run_round();
        stim[0].pgrst = 1'b0;
        stim[0].keyon = 1'b0; stim[2].keyon = 1'b0;
        run_round();
        for (int s = 0; s < c_SLOTS; s++) stim[s].frz = 1'b1;
        run_round();
        stim[0].keyon = 1'b1;
        run_round();
        run_round();
        for (int s = 0; s < c_SLOTS; s++) stim[s].frz = 1'b0;
        repeat (2) run_round();

        // Vibrato corner cases on slots 1..4
        do_reset();
        clear_stim();
        for (int s = 1; s <= 4; s++) begin
            stim[s].fnum = 10'h380; stim[s].block = 3'd1; stim[s].mul = 4'd1;
            stim[s].viben = 1'b1;
        end
        stim[1].lfo = 3'd2; stim[2].lfo = 3'd6; stim[3].lfo = 3'd1;
        stim[4].lfo = 3'd2; stim[4].viben = 1'b0;
        vib_dep = 1'b1;
        repeat (6) run_round();
        vib_dep = 1'b0;
        nts = 1'b1;
        repeat (6) run_round();

        // Randomized traffic, enable gap, then reset in mid-round
        do_reset();
        for (int r = 0; r < 30; r++) begin
            vib_dep = 1'($urandom);
            nts = 1'($urandom);
            random_stim();
            run_round();
        end
        repeat (7) step();
        gap(5);
        do_reset();
        repeat (10) begin
            random_stim();
            run_round();
        end

        // Large instance counter wraps after slot 71
        do_reset();
        repeat (40) step();
        check("dut2_slot_mid", int'(slot2), 36);
        repeat (35) step();
        check("dut2_slot_last", int'(slot2), 71);
        step();
        check("dut2_slot_wrap", int'(slot2), 0);
        check("dut2_zero_wrap", int'(zero2), 1);

        repeat (3) step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtopl_pg_mux.md
# jtopl_pg_mux

Parametrised, time-multiplexed phase generator for the OPL family. It generalises the 2-operator/9-channel generator to any channel and operator count and to configurable accumulator and output widths. It adds key-on edge phase reset, a test freeze, a note-select keycode and an internal slot counter. It sits between the channel register file, which supplies fnum/block, and the envelope/operator stages, which consume `phase_IV` and `keycode_II`.

## Interface
- `CH`, 9: channels.
- `OPS`, 2: operators per channel (4 for OPL3 4-op). SLOTS = CH*OPS.
- `PHW`, 20: phase accumulator width, ≥ 18.
- `OUTW`, 10: phase output width, ≤ PHW.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-low (`rst`=0 resets).
- `cenop`  in  1  operator clock enable; nothing advances while low.
- `fnum_I`  in  10  F-number, stage I.
- `block_I`  in  3  octave, stage I.
- `lfo_pos_I`  in  3  vibrato LFO position, stage I.
- `viben_I`  in  1  vibrato enable, stage I.
- `vib_dep`  in  1  global vibrato depth (1 = deep).
- `nts`  in  1  note-select for keycode.
- `mul_II`  in  4  multiplier code, stage II.
- `keyon_II`  in  1  key state, stage II.
- `pg_rst_II`  in  1  forced phase reset, stage II.
- `test_frz`  in  1  freeze all accumulators.
- `keycode_II`  out  4  {block, nts ? fnum[8] : fnum[9]}.
- `slot_IV`  out  $clog2(SLOTS)  slot index aligned with `phase_IV`.
- `zero_IV`  out  1  high when `slot_IV`==0.
- `phase_IV`  out  OUTW  acc[PHW-1 -: OUTW].

## Operation
- **Slot counter:** increments on each `cenop` and wraps SLOTS-1→0. Slot s is presented at stage I while the counter equals s.
- **Vibrato (stage I):**
  - r = fnum[9:7].
  - If `lfo_pos`[0], r >>= 1.
  - If !`vib_dep`, r >>= 1.
  - If `lfo_pos`[1:0]==0 or !`viben_I`, r = 0.
  - fnum_v = fnum + r when `lfo_pos`[2]==0, otherwise fnum − r. fnum_v is 11 bits unsigned and never underflows.
- **Increment (stage I, registered into II):** phinc = (fnum_v << block) >> 1, 17 bits.
- **Multiply (stage II):** the table gives ×2 factors {1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30}. inc = (phinc × tab[mul]) >> 1, truncated to PHW bits.
- **Accumulate (stage II→III):**
  - acc_new = acc + inc, modulo 2^PHW.
  - acc_new = 0 if `pg_rst_II`, or if `keyon_II` is 1 while that slot's stored key history is 0 (rising edge).
  - If `test_frz`, acc is kept unchanged; a reset still wins over freeze.
- **History:** `keyon_II` is stored per slot regardless of freeze.
- **Storage:** acc and key history, PHW+1 bits, circulate in a shift loop of exactly SLOTS `cenop` stages. A slot reads its own previous value once per round.
- **Reset (`rst`=0 on a clk edge):** all accumulators, histories, pipeline registers, slot counter and outputs go to 0, regardless of `cenop`. Reset mid-round restarts at slot 0.

## Timing
- Stage I inputs for slot s are sampled on a `cenop` edge.
- Stage II inputs for slot s are sampled one `cenop` later.
- `keycode_II` is valid in stage II.
- `phase_IV` and `slot_IV`=s are valid 3 `cenop` edges after the stage I sample.
- The phase shown is the post-update value, so a reset slot shows 0 in that round.
- `cenop` low holds all state and outputs.
- Outputs are registered, with no combinational input→output path.

## Structure
- Shared package `jtopl_pkg`: the multiplier table, SLOTS computation and slot-width function.
- Storage loop reuses the existing `jtopl_sh_rst` shift register, instantiated as the single sub-module. Its reset is driven from the inverted active-low `rst`.
- Vibrato/increment logic lives inline in two always blocks (stage I comb, stage II add).

## Test plan
- **Reset:** hold `rst`=0 for 3 clk with `cenop`=1 → `phase_IV`=0, `slot_IV`=0, `zero_IV`=1, `keycode_II`=0.
- **Accumulation:** slot 0 fnum=0x200, block=4, mul=1, others fnum=0 → phinc=4096; after N rounds `phase_IV`=4N (mod 1024) for slot 0 and 0 for others. With mul=0: 2N. With mul=11: 40N.
- **Wrap:** same stimulus for 256 rounds → acc wraps to 0 and `phase_IV`=0 exactly at round 256.
- **Key-on edge:**
  - `keyon_II` 0→1 on round 10 → that slot shows 0 in round 10, then 4, 8, …
  - Holding keyon high → no further reset.
  - `pg_rst_II` pulse → 0 that round.
- **Vibrato:**
  - fnum=0x380, `vib_dep`=1, pos=2 → fnum_v=0x387.
  - pos=6 → 0x379.
  - pos=1, `vib_dep`=0 → 0x381.
  - `viben_I`=0 → 0x380.
- **Freeze, gating and reset mid-run:**
  - `test_frz`=1 for 3 rounds → phase constant, and a keyon edge still zeroes it.
  - `cenop`=0 for 5 clk → outputs stable.
  - `rst`=0 mid-round → all 0, and the counter restarts at 0.
  - CH=18, OPS=4 instance → counter wraps at 71.
